manchester_tx_ctrl: RTL and testbench

//  Frame sequencer for the Manchester transmit path: accepts a DATA_W-bit word via valid/ready,

---
 rtl/manchester_pkg.sv | 16 +
 rtl/manchester_tx_ctrl_if.sv | 23 ++
 rtl/mtx_half_tick.sv | 34 +++
 rtl/manchester_tx_ctrl.sv | 148 ++++++++++++++
 tb/tb_manchester_tx_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester transmit sequencer.
// Line encoding is IEEE 802.3: first half-bit carries ~b, second half-bit carries b.
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;

  function automatic bit man_half(bit b, bit half);
    return half ? b : ~b;
  endfunction

endpackage

// File: rtl/manchester_tx_ctrl_if.sv
// Host-side word handshake for the Manchester transmitter.
// The host drives data and valid; the transmitter returns ready.
interface manchester_tx_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/mtx_half_tick.sv
// Half-bit timebase: free-running 0..DIV-1 counter with a synchronous clear.
// o_tick marks the last clock of each half-bit.
module mtx_half_tick #(
  parameter int DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clr,
  output logic [$clog2(DIV)-1:0] o_cnt,
  output logic                   o_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tick = w_tick;

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Manchester frame sequencer: accepts one word, then drives preamble, MSB-first data
// and a one-bit low trailer onto the line, all outputs registered.
module manchester_tx_ctrl
  import manchester_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int PRE_BITS = 8,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  manchester_tx_ctrl_if.slave tx_if,
  output logic                o_line_out,
  output logic                o_line_en,
  output logic                o_busy,
  output logic                o_done
);

  localparam int BC_MAX = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int BC_W   = $clog2(BC_MAX + 1);
  localparam int CNT_W  = $clog2(DIV);
  localparam logic [BC_W-1:0] PRE_LAST  = BC_W'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

  state_t            r_state;
  logic              r_half;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_line_out;
  logic              r_line_en;
  logic              r_busy;
  logic              r_done;
  logic              r_tx_ready;

  logic              w_accept;
  logic              w_tick;
  logic [CNT_W-1:0]  w_cnt_unused;
  logic [BC_W-1:0]   w_bit_cnt_inc;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_cur_bit;

  // Divider stays cleared while idle, so the accept edge always starts a fresh half-bit.
  mtx_half_tick #(
    .DIV (DIV)
  ) u_half_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (r_state == IDLE),
    .o_cnt  (w_cnt_unused),
    .o_tick (w_tick)
  );

  assign w_accept      = tx_if.tx_valid & r_tx_ready;
  assign w_bit_cnt_inc = r_bit_cnt + BC_W'(1);
  assign w_shift_nxt   = r_shift << 1;

  always_comb begin
    w_cur_bit = 1'b0;
    case (r_state)
      PRE:     w_cur_bit = ~r_bit_cnt[0];
      DATA:    w_cur_bit = r_shift[DATA_W-1];
      default: w_cur_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_half     <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_line_out <= 1'b0;
      r_line_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= tx_if.tx_data;
            r_half     <= 1'b0;
            r_bit_cnt  <= '0;
            r_line_en  <= 1'b1;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
            if (PRE_BITS > 0) begin
              r_state    <= PRE;
              r_line_out <= man_half(1'b1, 1'b0);
            end else begin
              r_state    <= DATA;
              r_line_out <= man_half(tx_if.tx_data[DATA_W-1], 1'b0);
            end
          end
        end
        default: begin
          if (w_tick && !r_half) begin
            r_half     <= 1'b1;
            r_line_out <= (r_state == STOP) ? 1'b0 : man_half(w_cur_bit, 1'b1);
          end else if (w_tick) begin
            // Bit boundary: load the first half of whatever bit comes next.
            r_half <= 1'b0;
            case (r_state)
              PRE: begin
                if (r_bit_cnt == PRE_LAST) begin
                  r_state    <= DATA;
                  r_bit_cnt  <= '0;
                  r_line_out <= man_half(r_shift[DATA_W-1], 1'b0);
                end else begin
                  r_bit_cnt  <= w_bit_cnt_inc;
                  r_line_out <= man_half(~w_bit_cnt_inc[0], 1'b0);
                end
              end
              DATA: begin
                r_shift <= w_shift_nxt;
                if (r_bit_cnt == DATA_LAST) begin
                  r_state    <= STOP;
                  r_bit_cnt  <= '0;
                  r_line_out <= 1'b0;
                end else begin
                  r_bit_cnt  <= w_bit_cnt_inc;
                  r_line_out <= man_half(w_shift_nxt[DATA_W-1], 1'b0);
                end
              end
              STOP: begin
                r_state    <= IDLE;
                r_done     <= 1'b1;
                r_line_en  <= 1'b0;
                r_line_out <= 1'b0;
                r_busy     <= 1'b0;
                r_tx_ready <= 1'b1;
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign tx_if.tx_ready = r_tx_ready;
  assign o_line_out     = r_line_out;
  assign o_line_en      = r_line_en;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_manchester_tx_ctrl.sv
// Bench for manchester_tx_ctrl: three parameterisations, each frame compared cycle by cycle
// against a line-level waveform built from the encoding rules.
module tb_manchester_tx_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] d  [3];
  logic       v  [3];
  logic       lo [3];
  logic       le [3];
  logic       bz [3];
  logic       dn [3];
  logic       rd [3];

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  manchester_tx_ctrl_if #(.DATA_W(8)) if0 ();
  manchester_tx_ctrl_if #(.DATA_W(8)) if1 ();
  manchester_tx_ctrl_if #(.DATA_W(8)) if2 ();

  assign if0.tx_data = d[0]; assign if0.tx_valid = v[0]; assign rd[0] = if0.tx_ready;
  assign if1.tx_data = d[1]; assign if1.tx_valid = v[1]; assign rd[1] = if1.tx_ready;
  assign if2.tx_data = d[2]; assign if2.tx_valid = v[2]; assign rd[2] = if2.tx_ready;

  manchester_tx_ctrl #(.DIV(2), .PRE_BITS(4), .DATA_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .tx_if(if0),
    .o_line_out(lo[0]), .o_line_en(le[0]), .o_busy(bz[0]), .o_done(dn[0]));
  manchester_tx_ctrl #(.DIV(2), .PRE_BITS(0), .DATA_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .tx_if(if1),
    .o_line_out(lo[1]), .o_line_en(le[1]), .o_busy(bz[1]), .o_done(dn[1]));
  manchester_tx_ctrl #(.DIV(5), .PRE_BITS(4), .DATA_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .tx_if(if2),
    .o_line_out(lo[2]), .o_line_en(le[2]), .o_busy(bz[2]), .o_done(dn[2]));

  function automatic int div_of(int idx);
    return (idx == 2) ? 5 : 2;
  endfunction

  function automatic int pre_of(int idx);
    return (idx == 1) ? 0 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line level for every clock of the frame: preamble 1,0,1,0..., data MSB first,
  // then one full bit time low; each symbol is (~b, b), each half DIV clocks long.
  function automatic void build_exp(int idx, logic [7:0] w);
    int dv;
    int sym[$];
    dv = div_of(idx);
    exp_q.delete();
    for (int i = 0; i < pre_of(idx); i++) sym.push_back((i % 2 == 0) ? 1 : 0);
    for (int j = 7; j >= 0; j--) sym.push_back(int'(w[j]));
    foreach (sym[k]) begin
      for (int c = 0; c < dv; c++) exp_q.push_back(1 - sym[k]);
      for (int c = 0; c < dv; c++) exp_q.push_back(sym[k]);
    end
    for (int c = 0; c < 2 * dv; c++) exp_q.push_back(0);
  endfunction

  task automatic run_frame(int idx, logic [7:0] word, bit keep, logic [7:0] nxt);
    int len;
    int bad_line;
    int bad_ctl;
    int en_cycles;
    string t;
    bad_line  = 0;
    bad_ctl   = 0;
    en_cycles = 0;
    t = $sformatf("d%0d_%02h", idx, word);
    build_exp(idx, word);
    len = exp_q.size();
    @(negedge clk);
    v[idx] = 1'b1;
    d[idx] = word;
    chk({t, "_ready_idle"}, 32'(rd[idx]), 1);
    @(posedge clk); #1;
    if (keep) d[idx] = nxt;
    else begin
      v[idx] = 1'b0;
      d[idx] = 8'($urandom);
    end
    for (int k = 0; k < len; k++) begin
      if (lo[idx] !== 1'(exp_q[k])) bad_line++;
      if (le[idx] === 1'b1) en_cycles++;
      if (rd[idx] !== 1'b0 || bz[idx] !== 1'b1 || dn[idx] !== 1'b0) bad_ctl++;
      @(posedge clk); #1;
    end
    chk({t, "_line_bad"}, 32'(bad_line), 0);
    chk({t, "_ctl_bad"}, 32'(bad_ctl), 0);
    chk({t, "_en_cycles"}, 32'(en_cycles), 32'(len));
    chk({t, "_done_pulse"}, 32'(dn[idx]), 1);
    chk({t, "_end_en"}, 32'(le[idx]), 0);
    chk({t, "_end_line"}, 32'(lo[idx]), 0);
    chk({t, "_end_ready"}, 32'(rd[idx]), 1);
    chk({t, "_end_busy"}, 32'(bz[idx]), 0);
    if (!keep) begin
      @(posedge clk); #1;
      chk({t, "_done_clear"}, 32'(dn[idx]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int         idx;
    bit         keep;

    // Reset held with valid asserted: nothing may be accepted.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1;
      d[i] = 8'hA5;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_ready", i), 32'(rd[i]), 1);
      chk($sformatf("rst%0d_line", i), 32'(lo[i]), 0);
      chk($sformatf("rst%0d_en", i), 32'(le[i]), 0);
      chk($sformatf("rst%0d_busy", i), 32'(bz[i]), 0);
      chk($sformatf("rst%0d_done", i), 32'(dn[i]), 0);
      v[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst_busy", 32'(bz[0]), 0);

    // Directed frames, including a word held valid across a busy frame.
    run_frame(0, 8'hA5, 1'b0, 8'h00);
    run_frame(0, 8'hA5, 1'b1, 8'h3C);
    run_frame(0, 8'h3C, 1'b0, 8'h00);
    run_frame(1, 8'h00, 1'b0, 8'h00);
    run_frame(2, 8'h80, 1'b0, 8'h00);

    // Asynchronous reset in the middle of data bit 3.
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'hA5;
    @(posedge clk); #1;
    v[0] = 1'b0;
    repeat (28) @(posedge clk);
    #2;
    chk("mid_rst_pre_en", 32'(le[0]), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_en", 32'(le[0]), 0);
    chk("mid_rst_line", 32'(lo[0]), 0);
    chk("mid_rst_busy", 32'(bz[0]), 0);
    chk("mid_rst_ready", 32'(rd[0]), 1);
    chk("mid_rst_done", 32'(dn[0]), 0);
    v[0] = 1'b1;
    d[0] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_accept_busy", 32'(bz[0]), 0);
    chk("rst_no_accept_en", 32'(le[0]), 0);
    v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_frame(0, 8'hFF, 1'b0, 8'h00);

    // Randomised traffic across all three configurations.
    for (int n = 0; n < 12; n++) begin
      idx  = $urandom_range(0, 2);
      w    = 8'($urandom);
      w2   = 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      run_frame(idx, w, keep, w2);
      if (keep) run_frame(idx, w2, 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
